// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared status codes, segment patterns and digit/segment types for the display scanner
package calc_pkg;
    localparam logic [1:0] ST_ERR   = 2'b00;
    localparam logic [1:0] ST_BUSY  = 2'b01;
    localparam logic [1:0] ST_READY = 2'b10;

    // Segment order {g,f,e,d,c,b,a}, active-low
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_r     = 7'b0101111;

    typedef logic [3:0] bcd_t;
    typedef logic [6:0] seg_t;
endpackage

// File: rtl/calc_display_scan_bcd_to_7seg.sv
// rtl/calc_display_scan_bcd_to_7seg.sv - combinational BCD to active-low 7-segment decoder, codes 10..15 blank
module bcd_to_7seg
    import calc_pkg::*;
(
    input  bcd_t digit,
    output seg_t seg
);
    always_comb begin
        seg = SEG_BLANK;
        case (digit)
            4'd0: seg = 7'b1000000;
            4'd1: seg = 7'b1111001;
            4'd2: seg = 7'b0100100;
            4'd3: seg = 7'b0110000;
            4'd4: seg = 7'b0011001;
            4'd5: seg = 7'b0010010;
            4'd6: seg = 7'b0000010;
            4'd7: seg = 7'b1111000;
            4'd8: seg = 7'b0000000;
            4'd9: seg = 7'b0010000;
            default: seg = SEG_BLANK;
        endcase
    end
endmodule

// File: rtl/calc_display_scan.sv
// rtl/calc_display_scan.sv - shadow/commit digit capture and multiplexed 7-seg scan; CALC_DISP_LZB_EN enables leading-zero blanking
module calc_display_scan
    import calc_pkg::*;
#(
    parameter int N_DIG    = 8,
    parameter int SCAN_DIV = 50000
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [1:0]       status,
    input  logic [3:0]       data,
    input  logic [3:0]       pos,
    output logic [N_DIG-1:0] an,
    output logic [6:0]       seg,
    output logic             busy_o
);
    localparam int IW = (N_DIG > 1) ? $clog2(N_DIG) : 1;
    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] PS_LAST  = PW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(N_DIG - 1);

    bcd_t             shadow  [N_DIG];
    bcd_t             display [N_DIG];
    logic [N_DIG-1:0] blank_mask;
    logic [N_DIG-1:0] lzb_mask;
    logic [1:0]       status_q;
    logic [PW-1:0]    prescaler;
    logic [IW-1:0]    index;
    logic             capture;
    logic             commit;
    seg_t             dec_seg;
    seg_t             seg_next;

    assign capture = (status == ST_BUSY) && (int'(pos) < N_DIG);
    assign commit  = (status_q == ST_BUSY) && (status == ST_READY);

`ifdef CALC_DISP_LZB_EN
    // Mask is derived from the shadow at commit time so the scan path only reads one bit
    always_comb begin
        logic seen;
        seen     = 1'b0;
        lzb_mask = '0;
        for (int i = N_DIG - 1; i > 0; i--) begin
            if (shadow[i] != 4'd0) seen = 1'b1;
            lzb_mask[i] = ~seen;
        end
    end
`else
    assign lzb_mask = '0;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N_DIG; i++) begin
                shadow[i]  <= 4'hF;
                display[i] <= 4'hF;
            end
            blank_mask <= '0;
            status_q   <= ST_BUSY;
            busy_o     <= 1'b0;
        end else begin
            status_q <= status;
            if (capture) begin
                shadow[pos[IW-1:0]] <= data;
                busy_o              <= 1'b1;
            end else if (commit) begin
                for (int i = 0; i < N_DIG; i++) display[i] <= shadow[i];
                blank_mask <= lzb_mask;
                busy_o     <= 1'b0;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            prescaler <= '0;
            index     <= '0;
        end else if (prescaler == PS_LAST) begin
            prescaler <= '0;
            index     <= (index == IDX_LAST) ? '0 : index + 1'b1;
        end else begin
            prescaler <= prescaler + 1'b1;
        end
    end

    bcd_to_7seg u_dec (
        .digit(display[index]),
        .seg  (dec_seg)
    );

    // Error overlay reads the live status so leaving error restores the buffer on the next render
    always_comb begin
        seg_next = blank_mask[index] ? SEG_BLANK : dec_seg;
        if (status == ST_ERR) begin
            if (index == IW'(0) || index == IW'(1)) seg_next = SEG_r;
            else if (index == IW'(2))               seg_next = SEG_E;
            else                                    seg_next = SEG_BLANK;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            an  <= '1;
            seg <= SEG_BLANK;
        end else begin
            an  <= ~(N_DIG'(1) << index);
            seg <= seg_next;
        end
    end
endmodule

// File: tb/tb_calc_display_scan.sv
// tb/tb_calc_display_scan.sv - randomized and directed self-checking bench for calc_display_scan against a digit-array model
module tb_calc_display_scan;
    localparam int N_DIG    = 8;
    localparam int SCAN_DIV = 4;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [1:0] status = 2'b10;
    logic [3:0] data = 4'd0;
    logic [3:0] pos = 4'd15;
    logic [7:0] an;
    logic [6:0] seg;
    logic       busy_o;

    int checks   = 0;
    int failures = 0;

    int         m_shadow [8];
    int         m_disp   [8];
    int         m_busy;
    logic [1:0] m_status_q;
    int         k;

    calc_display_scan #(.N_DIG(N_DIG), .SCAN_DIV(SCAN_DIV)) dut (
        .clock (clock),
        .reset (reset),
        .status(status),
        .data  (data),
        .pos   (pos),
        .an    (an),
        .seg   (seg),
        .busy_o(busy_o)
    );

    always #5 clock = ~clock;

    function automatic logic [6:0] dec(int d);
        case (d)
            0: return 7'h40;
            1: return 7'h79;
            2: return 7'h24;
            3: return 7'h30;
            4: return 7'h19;
            5: return 7'h12;
            6: return 7'h02;
            7: return 7'h78;
            8: return 7'h00;
            9: return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    function automatic logic [6:0] exp_seg(int idx);
`ifdef CALC_DISP_LZB_EN
        int msd;
`endif
        if (status == 2'b00) return (idx <= 1) ? 7'b0101111 : ((idx == 2) ? 7'b0000110 : 7'h7F);
`ifdef CALC_DISP_LZB_EN
        msd = 0;
        for (int i = 0; i < 8; i++) if (m_disp[i] != 0) msd = i;
        if (idx > msd) return 7'h7F;
`endif
        return dec(m_disp[idx]);
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            m_shadow[i] = 15;
            m_disp[i]   = 15;
        end
        m_busy     = 0;
        m_status_q = 2'b01;
        k          = 0;
    endtask

    // One clock: predict outputs from pre-edge state and inputs, advance the model, then compare
    task automatic step();
        int idx;
        logic [6:0] es;
        logic [7:0] ea;
        idx = (k / SCAN_DIV) % N_DIG;
        es  = exp_seg(idx);
        ea  = ~(8'd1 << idx);
        if (status == 2'b01 && pos < 8) begin
            m_shadow[pos] = data;
            m_busy        = 1;
        end else if (m_status_q == 2'b01 && status == 2'b10) begin
            for (int i = 0; i < 8; i++) m_disp[i] = m_shadow[i];
            m_busy = 0;
        end
        m_status_q = status;
        @(posedge clock);
        #1;
        k++;
        chk("an", 32'(an), 32'(ea));
        chk("seg", 32'(seg), 32'(es));
        chk("busy", 32'(busy_o), 32'(m_busy));
    endtask

    task automatic cyc(logic [1:0] st, logic [3:0] d, logic [3:0] p);
        status = st;
        data   = d;
        pos    = p;
        step();
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) cyc(2'b10, 4'd0, 4'd15);
    endtask

    task automatic do_reset();
        @(negedge clock);
        #2;
        reset = 1'b0;
        #1;
        chk("rst_an", 32'(an), 32'hFF);
        chk("rst_seg", 32'(seg), 32'h7F);
        chk("rst_busy", 32'(busy_o), 32'd0);
        model_reset();
        status = 2'b10;
        pos    = 4'd15;
        @(negedge clock);
        reset = 1'b1;
    endtask

    initial begin
        model_reset();
        do_reset();
        idle(8);

        // Print 42 then commit
        cyc(2'b01, 4'd2, 4'd0);
        cyc(2'b01, 4'd4, 4'd1);
        for (int p = 2; p < 8; p++) cyc(2'b01, 4'd0, 4'(p));
        cyc(2'b10, 4'd0, 4'd15);
        idle(40);

        // Second print directly after a commit; display holds until its own commit
        cyc(2'b01, 4'd7, 4'd0);
        cyc(2'b01, 4'd1, 4'd1);
        cyc(2'b10, 4'd0, 4'd15);
        for (int i = 0; i < 40; i++) cyc(2'b01, 4'($urandom_range(0, 9)), 4'($urandom_range(0, 7)));
        cyc(2'b10, 4'd0, 4'd15);
        idle(36);

        // Error overlay and recovery
        for (int i = 0; i < 36; i++) cyc(2'b00, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
        idle(36);

        // Out-of-range position ignored, blank code 12 shown blank
        cyc(2'b01, 4'd3, 4'd0);
        cyc(2'b01, 4'd5, 4'd8);
        cyc(2'b01, 4'd12, 4'd3);
        cyc(2'b01, 4'd9, 4'd9);
        cyc(2'b10, 4'd0, 4'd15);
        idle(36);

        // Commit of zero
        for (int p = 0; p < 8; p++) cyc(2'b01, 4'd0, 4'(p));
        cyc(2'b10, 4'd0, 4'd15);
        idle(36);

        // Random prints with occasional error bursts
        for (int t = 0; t < 8; t++) begin
            int len;
            len = $urandom_range(1, 20);
            for (int i = 0; i < len; i++) cyc(2'b01, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 9)));
            cyc(2'b10, 4'd0, 4'd15);
            if ($urandom_range(0, 2) == 0)
                for (int i = 0; i < 10; i++) cyc(2'b00, 4'd0, 4'd0);
            idle($urandom_range(2, 34));
        end

        // Reset in the middle of a print
        for (int p = 0; p < 5; p++) cyc(2'b01, 4'(p + 1), 4'(p));
        do_reset();
        idle(36);
        cyc(2'b10, 4'd0, 4'd15);
        idle(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
